// File: rtl/mem_stage_pkg.sv
// Shared definitions for the RISC-V memory stage.
// Covers funct3 access codes, FSM encoding, the retire record and timeout sizing.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        reg_wr;
    logic        exc;
    logic [31:0] data;
  } retire_t;

  // Timeout counter width: clog2(TIMEOUT_CYC+1), never narrower than one bit.
  function automatic int tmo_width(input int cyc);
    int w;
    w = $clog2(cyc + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data bus between the memory stage (master) and the data memory (slave).
// Handshake: dbus_req holds high with addr/we/be/wdata stable until the edge
// that samples dbus_ack=1; dbus_rdata is valid only with that ack, and an
// ack seen while dbus_req=0 carries no meaning.
interface mem_stage_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_rdata;
  logic        dbus_ack;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
    input  dbus_rdata, dbus_ack
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
    output dbus_rdata, dbus_ack
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the memory stage: store data/byte enables from the
// incoming op, and extraction/extension of load data for the outstanding op.
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] st_data_i,
  input  logic [1:0]  st_off_i,
  input  logic [2:0]  st_f3_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic        misalign_o,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  ld_off_i,
  input  logic [2:0]  ld_f3_i,
  output logic [31:0] ld_val_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    wdata_o    = st_data_i;
    be_o       = 4'b0000;
    misalign_o = 1'b0;
    case (st_f3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << st_off_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      2'b01: begin
        be_o       = st_off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{st_data_i[15:0]}};
        misalign_o = st_off_i[0];
      end
      2'b10: begin
        be_o       = 4'b1111;
        misalign_o = |st_off_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte  = rdata_i[{ld_off_i, 3'b000} +: 8];
    ld_half  = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    ld_val_o = rdata_i;
    case (ld_f3_i)
      F3_B:    ld_val_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_val_o = {24'h0, ld_byte};
      F3_H:    ld_val_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_val_o = {16'h0, ld_half};
      F3_W:    ld_val_o = rdata_i;
      default: ld_val_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: runs the data-bus transaction for loads/stores, stalls the
// pipeline while one is outstanding, and registers the MEM/WB retire.
module mem_stage
  import riscv_mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_y,
  input  logic [31:0] ex_rs2_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_wr,
  input  logic        ex_mem_rd,
  input  logic        ex_mem_wr,
  input  logic [2:0]  ex_funct3,
  output logic        mem_stall,
  mem_stage_if.master dbus,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_wr,
  output logic [31:0] wb_data,
  output logic        mem_exc,
  output mem_state_e  dbg_state_o
);

  localparam int TW = tmo_width(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;

  mem_state_e  state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  ld_f3_q, ld_f3_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic        is_ld_q, is_ld_d, reg_wr_q, reg_wr_d;
  logic [4:0]  rd_q, rd_d;
  logic [TW-1:0] cnt_q, cnt_d;
  retire_t     wb_q, wb_d, pend_q, pend_d;

  logic [31:0] al_wdata, al_ld_val;
  logic [3:0]  al_be;
  logic        al_misalign;
  logic        is_mem, bad_f3, exc_op, accept, acc_mem, tmo_hit;
  retire_t     acc_ret, bus_ret, wb_sel;

  mem_lane_align u_align (
    .st_data_i  (ex_rs2_data),
    .st_off_i   (ex_alu_y[1:0]),
    .st_f3_i    (ex_funct3),
    .wdata_o    (al_wdata),
    .be_o       (al_be),
    .misalign_o (al_misalign),
    .rdata_i    (dbus.dbus_rdata),
    .ld_off_i   (ld_off_q),
    .ld_f3_i    (ld_f3_q),
    .ld_val_o   (al_ld_val)
  );

  assign is_mem    = ex_mem_rd | ex_mem_wr;
  assign bad_f3    = (ex_funct3[1:0] == 2'b11) || (ex_funct3 == 3'b110);
  assign exc_op    = is_mem && (al_misalign || bad_f3 || (ex_mem_wr && ex_funct3[2]) ||
                                (ex_mem_rd && ex_mem_wr));
  assign mem_stall = (state_q == ST_BUS) && !dbus.dbus_ack;
  assign accept    = ex_valid && !mem_stall;
  assign acc_mem   = accept && is_mem && !exc_op;
  assign tmo_hit   = (TIMEOUT_CYC > 0) && (cnt_q == TMO_LAST);

  always_comb begin
    acc_ret.valid  = accept && (!is_mem || exc_op);
    acc_ret.rd     = ex_rd;
    acc_ret.reg_wr = !is_mem && ex_reg_wr;
    acc_ret.exc    = exc_op;
    acc_ret.data   = ex_alu_y;
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    ld_f3_d  = ld_f3_q;
    ld_off_d = ld_off_q;
    is_ld_d  = is_ld_q;
    reg_wr_d = reg_wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    bus_ret  = '0;
    wb_sel   = '0;
    pend_d   = '0;

    if (state_q == ST_BUS) begin
      if (dbus.dbus_ack) begin
        bus_ret.valid  = 1'b1;
        bus_ret.rd     = rd_q;
        bus_ret.reg_wr = is_ld_q & reg_wr_q;
        bus_ret.data   = is_ld_q ? al_ld_val : 32'h0;
        req_d          = 1'b0;
        state_d        = ST_IDLE;
        cnt_d          = '0;
      end else if (tmo_hit) begin
        bus_ret.valid = 1'b1;
        bus_ret.rd    = rd_q;
        bus_ret.exc   = 1'b1;
        req_d         = 1'b0;
        state_d       = ST_IDLE;
        cnt_d         = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (acc_mem) begin
      state_d  = ST_BUS;
      req_d    = 1'b1;
      we_d     = ex_mem_wr;
      addr_d   = {ex_alu_y[31:2], 2'b00};
      be_d     = al_be;
      wdata_d  = ex_mem_wr ? al_wdata : 32'h0;
      ld_f3_d  = ex_funct3;
      ld_off_d = ex_alu_y[1:0];
      is_ld_d  = ex_mem_rd;
      reg_wr_d = ex_reg_wr;
      rd_d     = ex_rd;
      cnt_d    = '0;
    end

    // A 1-cycle op accepted on an ack edge collides with the bus retire, so it
    // waits one cycle in pend_q; only one retire reaches writeback per cycle.
    if (bus_ret.valid) begin
      wb_sel = bus_ret;
      pend_d = acc_ret;
    end else if (pend_q.valid) begin
      wb_sel = pend_q;
      pend_d = acc_ret;
    end else begin
      wb_sel = acc_ret;
    end

    wb_d = wb_sel;
    if (!wb_sel.valid) begin
      wb_d        = wb_q;
      wb_d.valid  = 1'b0;
      wb_d.reg_wr = 1'b0;
      wb_d.exc    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      be_q     <= 4'h0;
      ld_f3_q  <= 3'h0;
      ld_off_q <= 2'h0;
      is_ld_q  <= 1'b0;
      reg_wr_q <= 1'b0;
      rd_q     <= 5'h0;
      cnt_q    <= '0;
      wb_q     <= '0;
      pend_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      ld_f3_q  <= ld_f3_d;
      ld_off_q <= ld_off_d;
      is_ld_q  <= is_ld_d;
      reg_wr_q <= reg_wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      wb_q     <= wb_d;
      pend_q   <= pend_d;
    end
  end

  assign dbus.dbus_req   = req_q;
  assign dbus.dbus_we    = we_q;
  assign dbus.dbus_addr  = addr_q;
  assign dbus.dbus_wdata = wdata_q;
  assign dbus.dbus_be    = be_q;
  assign wb_valid        = wb_q.valid;
  assign wb_rd           = wb_q.rd;
  assign wb_reg_wr       = wb_q.reg_wr;
  assign wb_data         = wb_q.data;
  assign mem_exc         = wb_q.exc;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a short timeout (4 cycles).
module tb_mem_stage;
  import riscv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_reg_wr, ex_mem_rd, ex_mem_wr;
  logic [31:0] ex_alu_y, ex_rs2_data;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic        mem_stall, wb_valid, wb_reg_wr, mem_exc;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  mem_state_e  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT_CYC(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .ex_alu_y    (ex_alu_y),
    .ex_rs2_data (ex_rs2_data),
    .ex_rd       (ex_rd),
    .ex_reg_wr   (ex_reg_wr),
    .ex_mem_rd   (ex_mem_rd),
    .ex_mem_wr   (ex_mem_wr),
    .ex_funct3   (ex_funct3),
    .mem_stall   (mem_stall),
    .dbus        (bus),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_reg_wr   (wb_reg_wr),
    .wb_data     (wb_data),
    .mem_exc     (mem_exc),
    .dbg_state_o (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                       input logic [31:0] y, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic reg_wr);
    ex_valid    = 1'b1;
    ex_mem_rd   = rd_op;
    ex_mem_wr   = wr_op;
    ex_funct3   = f3;
    ex_alu_y    = y;
    ex_rs2_data = rs2;
    ex_rd       = rd;
    ex_reg_wr   = reg_wr;
  endtask

  task automatic idle_ex();
    ex_valid  = 1'b0;
    ex_mem_rd = 1'b0;
    ex_mem_wr = 1'b0;
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ret(input string tag, input logic [4:0] rd, input logic reg_wr,
                         input logic exc, input bit with_data);
    logic [31:0] exp_d;
    chk({tag, "_valid"}, wb_valid, 1);
    chk({tag, "_rd"}, wb_rd, rd);
    chk({tag, "_regwr"}, wb_reg_wr, reg_wr);
    chk({tag, "_exc"}, mem_exc, exc);
    if (with_data && exp_q.size() > 0) begin
      exp_d = exp_q.pop_front();
      chk({tag, "_data"}, wb_data, exp_d);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_ex();
    ex_funct3 = 3'b000; ex_alu_y = 32'h0; ex_rs2_data = 32'h0;
    ex_rd = 5'd0; ex_reg_wr = 1'b0;
    bus.dbus_ack = 1'b0; bus.dbus_rdata = 32'h0;

    #12;
    chk("rst_req", bus.dbus_req, 0);
    chk("rst_be", bus.dbus_be, 0);
    chk("rst_addr", bus.dbus_addr, 0);
    chk("rst_wvalid", wb_valid, 0);
    chk("rst_wdata", wb_data, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // non-memory op
    issue(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
    tick(); idle_ex();
    exp_q.push_back(32'h0000_1234);
    chk_ret("alu", 5'd5, 1'b1, 1'b0, 1);
    chk("alu_req", bus.dbus_req, 0);
    tick();
    chk("alu_bubble", wb_valid, 0);

    // lb at 0x103, three wait cycles
    issue(1'b1, 1'b0, F3_B, 32'h0000_0103, 32'h0, 5'd7, 1'b1);
    tick(); idle_ex(); #1;
    chk("lb_req", bus.dbus_req, 1);
    chk("lb_addr", bus.dbus_addr, 32'h100);
    chk("lb_be", bus.dbus_be, 4'b1000);
    chk("lb_we", bus.dbus_we, 0);
    chk("lb_stall1", mem_stall, 1);
    chk("lb_state", dbg_state, ST_BUS);
    chk("lb_wait_bubble", wb_valid, 0);
    tick(); chk("lb_stall2", mem_stall, 1);
    tick(); chk("lb_stall3", mem_stall, 1);
    tick();
    bus.dbus_ack = 1'b1; bus.dbus_rdata = 32'h80FF_0000; #1;
    chk("lb_stall_ack", mem_stall, 0);
    chk("lb_hold_addr", bus.dbus_addr, 32'h100);
    tick(); bus.dbus_ack = 1'b0;
    exp_q.push_back(32'hFFFF_FF80);
    chk_ret("lb", 5'd7, 1'b1, 1'b0, 1);
    chk("lb_req_drop", bus.dbus_req, 0);

    // sh at 0x202, ack in first cycle
    issue(1'b0, 1'b1, F3_H, 32'h0000_0202, 32'h0000_ABCD, 5'd4, 1'b1);
    tick(); idle_ex(); bus.dbus_ack = 1'b1; #1;
    chk("sh_be", bus.dbus_be, 4'b1100);
    chk("sh_wdata", bus.dbus_wdata, 32'hABCD_ABCD);
    chk("sh_we", bus.dbus_we, 1);
    chk("sh_addr", bus.dbus_addr, 32'h200);
    chk("sh_stall", mem_stall, 0);
    tick(); bus.dbus_ack = 1'b0;
    chk_ret("sh", 5'd4, 1'b0, 1'b0, 0);
    chk("sh_req_drop", bus.dbus_req, 0);

    // misaligned lw
    issue(1'b1, 1'b0, F3_W, 32'h0000_0201, 32'h0, 5'd6, 1'b1);
    tick(); idle_ex();
    chk_ret("lw_mis", 5'd6, 1'b0, 1'b1, 0);
    chk("lw_mis_req", bus.dbus_req, 0);
    tick();
    chk("lw_mis_exc_clr", mem_exc, 0);
    chk("lw_mis_req2", bus.dbus_req, 0);

    // back-to-back lhu then sw
    issue(1'b1, 1'b0, F3_HU, 32'h0000_0010, 32'h0, 5'd9, 1'b1);
    tick();
    issue(1'b0, 1'b1, F3_W, 32'h0000_0014, 32'h1122_3344, 5'd10, 1'b0);
    bus.dbus_ack = 1'b1; bus.dbus_rdata = 32'hBEEF_8001; #1;
    chk("lhu_req", bus.dbus_req, 1);
    chk("lhu_addr", bus.dbus_addr, 32'h10);
    chk("lhu_be", bus.dbus_be, 4'b0011);
    chk("lhu_stall", mem_stall, 0);
    tick(); idle_ex();
    exp_q.push_back(32'h0000_8001);
    chk_ret("lhu", 5'd9, 1'b1, 1'b0, 1);
    chk("sw_req", bus.dbus_req, 1);
    chk("sw_addr", bus.dbus_addr, 32'h14);
    chk("sw_we", bus.dbus_we, 1);
    chk("sw_be", bus.dbus_be, 4'b1111);
    chk("sw_wdata", bus.dbus_wdata, 32'h1122_3344);
    tick(); bus.dbus_ack = 1'b0;
    chk_ret("sw", 5'd10, 1'b0, 1'b0, 0);
    chk("sw_req_drop", bus.dbus_req, 0);

    // timeout after 4 BUS cycles
    issue(1'b1, 1'b0, F3_W, 32'h0000_0040, 32'h0, 5'd11, 1'b1);
    tick(); idle_ex();
    chk("tmo_req1", bus.dbus_req, 1);
    tick(); tick();
    chk("tmo_stall3", mem_stall, 1);
    tick();
    chk("tmo_req4", bus.dbus_req, 1);
    chk("tmo_no_exc_yet", mem_exc, 0);
    tick();
    chk_ret("tmo", 5'd11, 1'b0, 1'b1, 0);
    chk("tmo_req_drop", bus.dbus_req, 0);
    chk("tmo_state", dbg_state, ST_IDLE);
    tick();
    chk("tmo_exc_clr", mem_exc, 0);

    // sb lane, then back-to-back illegal encodings
    issue(1'b0, 1'b1, F3_B, 32'h0000_0301, 32'h0000_005A, 5'd0, 1'b0);
    tick(); idle_ex(); bus.dbus_ack = 1'b1; #1;
    chk("sb_be", bus.dbus_be, 4'b0010);
    chk("sb_wdata", bus.dbus_wdata, 32'h5A5A_5A5A);
    tick(); bus.dbus_ack = 1'b0;
    chk("sb_retire", wb_valid, 1);
    issue(1'b1, 1'b0, 3'b011, 32'h0, 32'h0, 5'd12, 1'b1);
    tick();
    issue(1'b0, 1'b1, F3_BU, 32'h0, 32'h0, 5'd13, 1'b0);
    chk_ret("f3_011", 5'd12, 1'b0, 1'b1, 0);
    tick();
    issue(1'b1, 1'b1, F3_W, 32'h0, 32'h0, 5'd14, 1'b1);
    chk_ret("sbu", 5'd13, 1'b0, 1'b1, 0);
    tick(); idle_ex();
    chk_ret("rd_wr", 5'd14, 1'b0, 1'b1, 0);
    chk("illegal_req", bus.dbus_req, 0);

    // ALU op accepted on the ack edge retires the following cycle
    issue(1'b1, 1'b0, F3_W, 32'h0000_0030, 32'h0, 5'd13, 1'b1);
    tick();
    issue(1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 5'd3, 1'b1);
    bus.dbus_ack = 1'b1; bus.dbus_rdata = 32'hCAFE_F00D;
    tick(); idle_ex(); bus.dbus_ack = 1'b0;
    exp_q.push_back(32'hCAFE_F00D);
    chk_ret("lw_ack", 5'd13, 1'b1, 1'b0, 1);
    chk("lw_ack_req", bus.dbus_req, 0);
    tick();
    exp_q.push_back(32'h0000_0055);
    chk_ret("alu_after_ack", 5'd3, 1'b1, 1'b0, 1);
    tick();
    chk("alu_after_bubble", wb_valid, 0);

    // reset in the middle of a transaction
    issue(1'b1, 1'b0, F3_W, 32'h0000_0080, 32'h0, 5'd14, 1'b1);
    tick(); idle_ex();
    chk("mid_req", bus.dbus_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", bus.dbus_req, 0);
    chk("mid_rst_state", dbg_state, ST_IDLE);
    chk("mid_rst_wvalid", wb_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    bus.dbus_ack = 1'b1; bus.dbus_rdata = 32'h1234_5678; #1;
    chk("late_ack_stall", mem_stall, 0);
    tick(); bus.dbus_ack = 1'b0;
    chk("late_ack_wvalid", wb_valid, 0);
    chk("late_ack_req", bus.dbus_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
